line_fetch_ctrl: RTL and testbench
==================================

# line_fetch_ctrl

Line-prefetch controller between the framebuffer read port and the VGA timing generator. It watches the generator's column/row addresses and fetches the next visible line from memory, in fixed-length bursts, into a ping-pong line buffer. While line r is displayed, it fetches line r+1. It returns RGB for the current pixel to the generator's colour inputs.

## Interface
- HBITS, 11, column address width
- VBITS, 10, row address width
- HVISIBLE, 800, visible pixels per line; must be a multiple of BURST_LEN
- VVISIBLE, 600, visible lines per frame
- ADDR_BITS, 20, memory word address width
- BURST_LEN, 16, words per read burst (power of two)
- FB_BASE, 0, word address of pixel (0,0); one 24-bit word per pixel, line stride HVISIBLE

Ports:
- clk  in  1  single clock for everything
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- column_addr  in  HBITS  current column from the timing generator
- row_addr  in  VBITS  current row from the timing generator
- visible  in  1  active-region flag from the timing generator
- rd_req  out  1  burst read request
- rd_addr  out  ADDR_BITS  first word address of the burst
- rd_ack  in  1  request accepted this cycle
- rd_valid  in  1  one data beat
- rd_data  in  24  {R[23:16],G[15:8],B[7:0]}
- red_out, green_out, blue_out  out  8 each  pixel to the timing generator
- fetch_busy  out  1  fetch in progress
- underrun  out  1  sticky fetch-overrun flag
- underrun_count  out  8  saturating overrun counter
- underrun_clr  in  1  clears underrun and underrun_count

## Operation
- Trigger event: column_addr==0, sampled once per line, with the edge detected against the previous cycle's column_addr.
  - If row_addr < VVISIBLE-1: fetch next_row = row_addr+1.
  - If row_addr == VVISIBLE: fetch next_row = 0.
  - No other rows trigger a fetch.
- Destination buffer is next_row[0]. Display buffer is row_addr[0].
- Burst address: rd_addr = FB_BASE + next_row*HVISIBLE + burst_idx*BURST_LEN, truncated to ADDR_BITS. There are HVISIBLE/BURST_LEN bursts per line.
- Beats are written to buffer offset burst_idx*BURST_LEN + beat_idx.
- FSM states:
  - IDLE: on trigger, go to REQ, with burst_idx=0.
  - REQ: rd_req=1 and rd_addr held stable until rd_ack. On rd_ack, go to DATA.
  - DATA: count BURST_LEN rd_valid beats. On the last beat, go to REQ if more bursts remain, otherwise to IDLE.
  - DRAIN: discard the remaining beats of an aborted burst. Then go to REQ for the pending row.
- Trigger while not in IDLE (overrun):
  - From REQ with no ack yet: restart in REQ with the new row.
  - From DATA: go to DRAIN.
  - In both cases the pending row replaces the old one, and an overrun is recorded (see Configuration).
- rd_valid outside DATA/DRAIN is ignored. rd_ack outside REQ is ignored.
- fetch_busy = (state != IDLE).
- RGB outputs are 0 when visible was 0 in the previous cycle.

## Timing
- Reset values: rd_req=0, rd_addr=0, RGB=0, fetch_busy=0, underrun=0, underrun_count=0, state IDLE, trigger edge detector cleared.
- Reset mid-burst: the fetch is abandoned with no drain, and buffer contents are undefined.
- Pixel latency is 1 cycle. RGB at cycle t+1 is the buffer word for column_addr and row_addr at cycle t. The integrator delays the sync signals by one cycle.
- rd_req rises the cycle after the trigger. Back-to-back bursts: rd_req rises the cycle after the last beat.
- underrun_clr has priority over a simultaneous overrun increment.
- A buffer write and a display read of the same buffer in the same cycle cannot occur by construction (different row parity). No bypass is needed.

## Configuration
- Macro LINE_FETCH_UNDERRUN_EN.
- Defined: each overrun sets underrun and increments underrun_count, saturating at 255.
- Undefined: underrun and underrun_count are tied to 0 and underrun_clr is ignored. Overrun recovery behaves identically.

## Structure
- Package line_fetch_pkg holds:
  - the FSM state enum (IDLE, REQ, DATA, DRAIN);
  - the 24-bit pixel typedef;
  - the derived constants BURSTS_PER_LINE = HVISIBLE/BURST_LEN and BUF_WORDS = 2*HVISIBLE.
- Sub-module line_buffer_dp: simple dual-port RAM, BUF_WORDS x 24, with one write port and one synchronous read port.

## Test plan
- Reset: drive rst=0 for 3 cycles during DATA -> rd_req=0, fetch_busy=0, RGB=0, underrun=0 on the first cycle with rst=1.
- Frame-start fetch: row_addr=600, column_addr 1->0, rd_ack the cycle after rd_req, 16 beats per burst -> 50 bursts at rd_addr 0,16,...,784; fetch_busy falls after the 800th beat.
- Line fetch and readout: at row 5 column 0 -> rd_addr starts at 4800. Feed beat k = 24'h000000+k. Then at row 6, column 10, visible=1 -> RGB = {0,0,10} one cycle later.
- Stalled grant: hold rd_ack=0 for 20 cycles -> rd_req=1 and rd_addr=4800 stable throughout; DATA entered only after the ack.
- Overrun: trigger row 7 while 5 beats of a burst are in flight -> underrun=1, underrun_count=1, 11 beats discarded, next rd_addr=6400. underrun_clr -> both cleared.
- Blanking: visible=0 with nonzero buffer contents -> RGB=0 one cycle later.

Source files
------------

// File: rtl/line_fetch_pkg.sv
// Shared types and default geometry for the framebuffer line-prefetch controller.
package line_fetch_pkg;

    localparam int unsigned HVISIBLE_DEF    = 800;
    localparam int unsigned BURST_LEN_DEF   = 16;
    localparam int unsigned BURSTS_PER_LINE = HVISIBLE_DEF / BURST_LEN_DEF;
    localparam int unsigned BUF_WORDS       = 2 * HVISIBLE_DEF;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line storage: one write port, one registered read port.
module line_buffer_dp
    import line_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = BUF_WORDS,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  pixel_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output pixel_t        rdata_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_fetch_ctrl.sv
// Prefetches the next visible line into a ping-pong buffer and serves pixels to the VGA generator.
// Optional overrun accounting is enabled with LINE_FETCH_UNDERRUN_EN.
module line_fetch_ctrl
    import line_fetch_pkg::*;
#(
    parameter int unsigned HBITS     = 11,
    parameter int unsigned VBITS     = 10,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned HVISIBLE  = BURSTS_PER_LINE * BURST_LEN_DEF,
    parameter int unsigned VVISIBLE  = 600,
    parameter int unsigned ADDR_BITS = 20,
    parameter int unsigned FB_BASE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HBITS-1:0]     column_addr,
    input  logic [VBITS-1:0]     row_addr,
    input  logic                 visible,
    output logic                 rd_req,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic                 rd_ack,
    input  logic                 rd_valid,
    input  logic [23:0]          rd_data,
    output logic [7:0]           red_out,
    output logic [7:0]           green_out,
    output logic [7:0]           blue_out,
    output logic                 fetch_busy,
    output logic                 underrun,
    output logic [7:0]           underrun_count,
    input  logic                 underrun_clr
);

    localparam int unsigned NBURSTS = HVISIBLE / BURST_LEN;
    localparam int unsigned BIDX_W  = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;
    localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned DEPTH   = 2 * HVISIBLE;
    localparam int unsigned AW      = $clog2(DEPTH);

    fetch_state_t          state_q, state_d;
    logic [VBITS-1:0]      row_q, row_d;
    logic [BIDX_W-1:0]     bidx_q, bidx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [HBITS-1:0]      col_prev_q;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  vis_q;

    logic                  trig, overrun, buf_we, last_beat, last_burst;
    logic [VBITS-1:0]      trig_row;
    logic [AW-1:0]         waddr, raddr;
    pixel_t                rdata;

    // New-line trigger: falling edge of column onto 0, qualified by row.
    always_comb begin
        trig     = 1'b0;
        trig_row = '0;
        if ((column_addr == '0) && (col_prev_q != '0)) begin
            if (32'(row_addr) < VVISIBLE - 1) begin
                trig     = 1'b1;
                trig_row = row_addr + VBITS'(1);
            end else if (32'(row_addr) == VVISIBLE) begin
                trig     = 1'b1;
                trig_row = '0;
            end
        end
    end

    assign last_beat  = rd_valid && (beat_q == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (bidx_q == BIDX_W'(NBURSTS - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        bidx_d  = bidx_q;
        beat_d  = beat_q;
        overrun = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = REQ;
                    row_d   = trig_row;
                    bidx_d  = '0;
                    beat_d  = '0;
                end
            end
            REQ: begin
                if (trig) begin
                    // An ack in the same cycle leaves a whole burst to discard.
                    overrun = 1'b1;
                    row_d   = trig_row;
                    bidx_d  = '0;
                    beat_d  = '0;
                    state_d = rd_ack ? DRAIN : REQ;
                end else if (rd_ack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (trig) begin
                    overrun = 1'b1;
                    row_d   = trig_row;
                    bidx_d  = '0;
                    if (last_beat) begin
                        state_d = REQ;
                        beat_d  = '0;
                    end else begin
                        state_d = DRAIN;
                        if (rd_valid) beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (rd_valid) begin
                    buf_we = 1'b1;
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_burst) begin
                            state_d = IDLE;
                        end else begin
                            bidx_d  = bidx_q + BIDX_W'(1);
                            state_d = REQ;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (trig) begin
                    overrun = 1'b1;
                    row_d   = trig_row;
                end
                if (last_beat) begin
                    state_d = REQ;
                    beat_d  = '0;
                end else if (rd_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        rd_req_d  = (state_d == REQ);
        busy_d    = (state_d != IDLE);
        rd_addr_d = rd_addr_q;
        if (state_d == REQ) begin
            rd_addr_d = ADDR_BITS'(FB_BASE + 32'(row_d) * HVISIBLE + 32'(bidx_d) * BURST_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            bidx_q     <= '0;
            beat_q     <= '0;
            col_prev_q <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            vis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            bidx_q     <= bidx_d;
            beat_q     <= beat_d;
            col_prev_q <= column_addr;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            vis_q      <= visible;
        end
    end

    // Destination half is the parity of the row being fetched; display half is the current row's parity.
    assign waddr = AW'(HVISIBLE * 32'(row_q[0]) + BURST_LEN * 32'(bidx_q) + 32'(beat_q));
    assign raddr = (32'(column_addr) < HVISIBLE) ?
                   AW'(HVISIBLE * 32'(row_addr[0]) + 32'(column_addr)) : '0;

    line_buffer_dp #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (waddr),
        .wdata_i (rd_data),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign fetch_busy = busy_q;
    assign red_out    = vis_q ? rdata[23:16] : 8'h00;
    assign green_out  = vis_q ? rdata[15:8]  : 8'h00;
    assign blue_out   = vis_q ? rdata[7:0]   : 8'h00;

`ifdef LINE_FETCH_UNDERRUN_EN
    logic       underrun_q, underrun_d;
    logic [7:0] ucnt_q, ucnt_d;

    // Clear wins over a coincident overrun; count saturates at 255.
    always_comb begin
        underrun_d = underrun_q;
        ucnt_d     = ucnt_q;
        if (underrun_clr) begin
            underrun_d = 1'b0;
            ucnt_d     = 8'h00;
        end else if (overrun) begin
            underrun_d = 1'b1;
            if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_q <= 1'b0;
            ucnt_q     <= 8'h00;
        end else begin
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;
`else
    logic unused_cfg;
    assign unused_cfg     = ^{overrun, underrun_clr};
    assign underrun       = 1'b0;
    assign underrun_count = 8'h00;
`endif

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Scoreboard bench for line_fetch_ctrl: expected burst addresses and pixels are queued by stimulus, popped by a monitor.
module tb_line_fetch_ctrl;

    localparam int unsigned HBITS     = 11;
    localparam int unsigned VBITS     = 10;
    localparam int unsigned ADDR_BITS = 20;
`ifdef LINE_FETCH_UNDERRUN_EN
    localparam logic UR_EN = 1'b1;
`else
    localparam logic UR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [HBITS-1:0]     column_addr;
    logic [VBITS-1:0]     row_addr;
    logic                 visible;
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_ack;
    logic                 rd_valid;
    logic [23:0]          rd_data;
    logic [7:0]           red_out, green_out, blue_out;
    logic                 fetch_busy;
    logic                 underrun;
    logic [7:0]           underrun_count;
    logic                 underrun_clr;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_addr_q[$];
    logic [23:0] exp_pix_q[$];
    logic        pix_probe;

    always #5 clk = ~clk;

    line_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .column_addr    (column_addr),
        .row_addr       (row_addr),
        .visible        (visible),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ack         (rd_ack),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out),
        .fetch_busy     (fetch_busy),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .underrun_clr   (underrun_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input int row);
        row_addr    = VBITS'(row);
        column_addr = HBITS'(1);
        tick();
        column_addr = '0;
        tick();
        column_addr = HBITS'(1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!rd_req && n < 100) begin
            tick();
            n++;
        end
        chk("req_wait", 32'(rd_req), 32'd1);
    endtask

    task automatic ack_burst();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic beats(input logic [23:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            rd_valid = 1'b1;
            rd_data  = first + 24'(k);
            tick();
        end
        rd_valid = 1'b0;
    endtask

    // Monitor: pixel compare one cycle after a probe, address compare on each rd_req rise.
    task automatic monitor();
        logic        req_prev;
        logic        probe_seen;
        logic [23:0] ep;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            probe_seen = pix_probe;
            @(negedge clk);
            if (probe_seen) begin
                if (exp_pix_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pixel_unexpected: got %h%h%h with empty queue", red_out, green_out, blue_out);
                end else begin
                    ep = exp_pix_q.pop_front();
                    chk("pixel", {8'h0, red_out, green_out, blue_out}, {8'h0, ep});
                end
            end
            if (rd_req && !req_prev) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd_addr_unexpected: got 0x%0h with empty queue", rd_addr);
                end else begin
                    chk("rd_addr", 32'(rd_addr), exp_addr_q.pop_front());
                end
            end
            req_prev = rd_req;
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        pix_probe    = 1'b0;
        rst          = 1'b0;
        column_addr  = '0;
        row_addr     = '0;
        visible      = 1'b0;
        rd_ack       = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        underrun_clr = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        rst = 1'b1;
        chk("rst_req",   32'(rd_req), 32'd0);
        chk("rst_addr",  32'(rd_addr), 32'd0);
        chk("rst_busy",  32'(fetch_busy), 32'd0);
        chk("rst_rgb",   {8'h0, red_out, green_out, blue_out}, 32'd0);
        chk("rst_ur",    32'(underrun), 32'd0);
        chk("rst_urcnt", 32'(underrun_count), 32'd0);

        // Frame start: row 600 fetches row 0, 50 bursts at 0..784.
        for (int b = 0; b < 50; b++) exp_addr_q.push_back(32'(b * 16));
        trigger(600);
        chk("frame_busy", 32'(fetch_busy), 32'd1);
        for (int b = 0; b < 50; b++) begin
            if (b == 0) wait_req();
            else chk("frame_b2b_req", 32'(rd_req), 32'd1);
            ack_burst();
            beats(24'hA00000 + 24'(b * 16), 16);
        end
        chk("frame_busy_end", 32'(fetch_busy), 32'd0);
        chk("frame_req_end",  32'(rd_req), 32'd0);

        // Row 5 fetches row 6 at 4800, first grant stalled 20 cycles with stray beats.
        for (int b = 0; b < 50; b++) exp_addr_q.push_back(32'(4800 + b * 16));
        trigger(5);
        rd_valid = 1'b1;
        rd_data  = 24'hFFFFFF;
        for (int i = 0; i < 20; i++) begin
            chk("stall_req",  32'(rd_req), 32'd1);
            chk("stall_addr", 32'(rd_addr), 32'd4800);
            tick();
        end
        rd_valid = 1'b0;
        ack_burst();
        chk("data_req_low", 32'(rd_req), 32'd0);
        chk("data_busy",    32'(fetch_busy), 32'd1);
        beats(24'h000000, 16);
        for (int b = 1; b < 50; b++) begin
            chk("line_b2b_req", 32'(rd_req), 32'd1);
            ack_burst();
            beats(24'(b * 16), 16);
        end
        chk("line_busy_end", 32'(fetch_busy), 32'd0);

        // Readout of row 6 and blanking.
        row_addr  = VBITS'(6);
        visible   = 1'b1;
        pix_probe = 1'b1;
        column_addr = HBITS'(10);  exp_pix_q.push_back(24'h00000A); tick();
        column_addr = HBITS'(11);  exp_pix_q.push_back(24'h00000B); tick();
        column_addr = HBITS'(799); exp_pix_q.push_back(24'h00031F); tick();
        visible = 1'b0;
        column_addr = HBITS'(10);  exp_pix_q.push_back(24'h000000); tick();
        visible = 1'b1;
        column_addr = HBITS'(12);  exp_pix_q.push_back(24'h00000C); tick();
        pix_probe = 1'b0;
        visible   = 1'b0;
        tick();
        tick();

        // Overrun: row 7 triggers after 5 beats of the row-7 fetch's first burst.
        exp_addr_q.push_back(32'd5600);
        exp_addr_q.push_back(32'd6400);
        exp_addr_q.push_back(32'd6416);
        trigger(6);
        wait_req();
        ack_burst();
        beats(24'h111100, 5);
        trigger(7);
        chk("ovr_busy",  32'(fetch_busy), 32'd1);
        chk("ovr_req",   32'(rd_req), 32'd0);
        chk("ovr_ur",    32'(underrun), 32'(UR_EN));
        chk("ovr_urcnt", 32'(underrun_count), UR_EN ? 32'd1 : 32'd0);
        beats(24'h222200, 10);
        chk("drain_req", 32'(rd_req), 32'd0);
        beats(24'h22220A, 1);
        chk("drain_done_req", 32'(rd_req), 32'd1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("clr_ur",    32'(underrun), 32'd0);
        chk("clr_urcnt", 32'(underrun_count), 32'd0);
        ack_burst();
        beats(24'h333300, 16);
        chk("ovr_b2b_req", 32'(rd_req), 32'd1);
        ack_burst();
        beats(24'h333310, 3);

        // Reset in the middle of a burst with a visible pixel selected.
        row_addr    = VBITS'(6);
        column_addr = HBITS'(20);
        visible     = 1'b1;
        rst         = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        chk("mid_rst_req",   32'(rd_req), 32'd0);
        chk("mid_rst_addr",  32'(rd_addr), 32'd0);
        chk("mid_rst_busy",  32'(fetch_busy), 32'd0);
        chk("mid_rst_rgb",   {8'h0, red_out, green_out, blue_out}, 32'd0);
        chk("mid_rst_ur",    32'(underrun), 32'd0);
        chk("mid_rst_urcnt", 32'(underrun_count), 32'd0);
        pix_probe = 1'b1;
        exp_pix_q.push_back(24'h000014);
        tick();
        pix_probe = 1'b0;
        visible   = 1'b0;
        tick();
        tick();

        chk("addr_queue_empty",  32'(exp_addr_q.size()), 32'd0);
        chk("pixel_queue_empty", 32'(exp_pix_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
